// File: rtl/bpu_pkg.sv
// Shared definitions for the branch predict unit: funct3 codes, ALU flag positions,
// predictor counter states and the BTB entry layout of the default configuration.
package bpu_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int FLAG_Z  = 0;
  localparam int FLAG_LT = 1;
  localparam int FLAG_C  = 2;

  localparam int BTB_XLEN  = 32;
  localparam int BTB_TAG_W = 8;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [BTB_XLEN-1:0]  target;
    ctr_e                 ctr;
  } btb_entry_t;

  // Saturating 2-bit counter step toward the resolved direction.
  function automatic ctr_e ctr_train(input ctr_e cur, input logic taken);
    ctr_e nxt;
    nxt = cur;
    unique case (cur)
      SNT: nxt = taken ? WNT : SNT;
      WNT: nxt = taken ? WT  : SNT;
      WT:  nxt = taken ? ST  : WNT;
      ST:  nxt = taken ? ST  : WT;
      default: nxt = WNT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation from funct3 and the ALU compare flags.
module branch_cond
  import bpu_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic [2:0] flags_i,
  output logic       cond_o
);

  always_comb begin
    cond_o = 1'b0;
    unique case (funct3_i)
      F3_BEQ:  cond_o =  flags_i[FLAG_Z];
      F3_BNE:  cond_o = ~flags_i[FLAG_Z];
      F3_BLT:  cond_o =  flags_i[FLAG_LT];
      F3_BGE:  cond_o = ~flags_i[FLAG_LT];
      F3_BLTU: cond_o = ~flags_i[FLAG_C];
      F3_BGEU: cond_o =  flags_i[FLAG_C];
      default: cond_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit counters: predicts in IF, resolves branches/jumps in EX,
// redirects on mispredict and trains the table at the next clock edge.
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   if_pc,
  output logic              if_pred_taken,
  output logic [XLEN-1:0]   if_pred_target,
  input  logic              ex_valid,
  input  logic              ex_branch,
  input  logic              ex_jump,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [2:0]        ex_funct3,
  input  logic [3:0]        ex_flags,
  input  logic [XLEN-1:0]   ex_target,
  input  logic              ex_pred_taken,
  input  logic [XLEN-1:0]   ex_pred_target,
  output logic              ex_redirect,
  output logic [XLEN-1:0]   ex_redirect_pc,
  output logic              ex_taken,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    ctr_e             ctr;
  } entry_t;

  entry_t btb_q [ENTRIES];
  entry_t ex_entry;
  entry_t entry_d;
  logic   train_we;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             cond;
  logic             resolve;
  logic             ex_hit;
  logic [XLEN-1:0]  ex_pc_plus4;

  logic [PERF_W-1:0] perf_branches_q, perf_branches_d;
  logic [PERF_W-1:0] perf_mispredicts_q, perf_mispredicts_d;

  // Address bits that are neither index nor tag, plus the spare flag bit.
  logic unused_bits;
  assign unused_bits = ^{ex_flags[3], if_pc[1:0], if_pc[XLEN-1:IDX_W+TAG_W+2]};

  branch_cond u_cond (
    .funct3_i (ex_funct3),
    .flags_i  (ex_flags[2:0]),
    .cond_o   (cond)
  );

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[IDX_W+2 +: TAG_W];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[IDX_W+2 +: TAG_W];

  // Lookup reads the registered table, so a same-cycle update is not visible yet.
  assign if_pred_taken  = btb_q[if_idx].valid && (btb_q[if_idx].tag == if_tag)
                          && btb_q[if_idx].ctr[1];
  assign if_pred_target = btb_q[if_idx].target;

  assign resolve     = ex_valid && (ex_branch || ex_jump);
  assign ex_taken    = ex_valid && (ex_jump || (ex_branch && cond));
  assign ex_pc_plus4 = ex_pc + XLEN'(4);

  always_comb begin
    ex_redirect    = 1'b0;
    ex_redirect_pc = ex_pc_plus4;
    if (resolve) begin
      if (ex_taken && (!ex_pred_taken || (ex_pred_target != ex_target))) begin
        ex_redirect    = 1'b1;
        ex_redirect_pc = ex_target;
      end else if (!ex_taken && ex_pred_taken) begin
        ex_redirect    = 1'b1;
      end
    end
  end

  assign ex_entry = btb_q[ex_idx];
  assign ex_hit   = ex_entry.valid && (ex_entry.tag == ex_tag);

  always_comb begin
    entry_d  = ex_entry;
    train_we = 1'b0;
    if (resolve) begin
      if (ex_hit) begin
        train_we    = 1'b1;
        entry_d.ctr = ctr_train(ex_entry.ctr, ex_taken);
        if (ex_taken) begin
          entry_d.target = ex_target;
        end
      end else if (ex_taken) begin
        train_we = 1'b1;
        entry_d  = '{valid: 1'b1, tag: ex_tag, target: ex_target,
                     ctr: (ex_jump ? ST : WT)};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
      end
    end else if (train_we) begin
      btb_q[ex_idx] <= entry_d;
    end
  end

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    perf_branches_d    = perf_branches_q;
    perf_mispredicts_d = perf_mispredicts_q;
    if (resolve && !(&perf_branches_q)) begin
      perf_branches_d = perf_branches_q + PERF_W'(1);
    end
    if (ex_redirect && !(&perf_mispredicts_q)) begin
      perf_mispredicts_d = perf_mispredicts_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches_q    <= '0;
      perf_mispredicts_q <= '0;
    end else begin
      perf_branches_q    <= perf_branches_d;
      perf_mispredicts_q <= perf_mispredicts_d;
    end
  end

  assign perf_branches    = perf_branches_q;
  assign perf_mispredicts = perf_mispredicts_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural table model.
module tb_branch_predict_unit;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;
  localparam int TAG_W   = 8;
  localparam int PERF_W  = 8;
  localparam int PERF_MAX = (1 << PERF_W) - 1;

  logic              clk;
  logic              rst_n;
  logic [XLEN-1:0]   if_pc;
  logic              if_pred_taken;
  logic [XLEN-1:0]   if_pred_target;
  logic              ex_valid, ex_branch, ex_jump;
  logic [XLEN-1:0]   ex_pc;
  logic [2:0]        ex_funct3;
  logic [3:0]        ex_flags;
  logic [XLEN-1:0]   ex_target;
  logic              ex_pred_taken;
  logic [XLEN-1:0]   ex_pred_target;
  logic              ex_redirect;
  logic [XLEN-1:0]   ex_redirect_pc;
  logic              ex_taken;
  logic [PERF_W-1:0] perf_branches, perf_mispredicts;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  int          m_br;
  int          m_mis;

  branch_predict_unit #(
    .XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .PERF_W(PERF_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_pc            (if_pc),
    .if_pred_taken    (if_pred_taken),
    .if_pred_target   (if_pred_target),
    .ex_valid         (ex_valid),
    .ex_branch        (ex_branch),
    .ex_jump          (ex_jump),
    .ex_pc            (ex_pc),
    .ex_funct3        (ex_funct3),
    .ex_flags         (ex_flags),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .ex_redirect      (ex_redirect),
    .ex_redirect_pc   (ex_redirect_pc),
    .ex_taken         (ex_taken),
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned m_tagof(input logic [31:0] pc);
    return (pc >> 6) & 32'hFF;
  endfunction

  function automatic bit m_cond(input logic [2:0] f3, input logic [3:0] fl);
    bit z, lt, c;
    z = fl[0]; lt = fl[1]; c = fl[2];
    if (f3 == 3'd0) return z;
    if (f3 == 3'd1) return !z;
    if (f3 == 3'd4) return lt;
    if (f3 == 3'd5) return !lt;
    if (f3 == 3'd6) return !c;
    if (f3 == 3'd7) return c;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_target[i] = '0; m_ctr[i] = 1;
    end
    m_br = 0;
    m_mis = 0;
  endtask

  // Expected EX results from the current inputs.
  function automatic void m_eval(output bit res, output bit tk, output bit red,
                                 output logic [31:0] rpc);
    res = ex_valid && (ex_branch || ex_jump);
    tk  = ex_valid && (ex_jump || (ex_branch && m_cond(ex_funct3, ex_flags)));
    red = res && ((tk && (!ex_pred_taken || ex_pred_target != ex_target)) ||
                  (!tk && ex_pred_taken));
    rpc = tk ? ex_target : ex_pc + 32'd4;
  endfunction

  // ---------------- model update ----------------
  always @(negedge rst_n) model_clear();

  always @(posedge clk) begin
    bit res, tk, red;
    logic [31:0] rpc;
    int i;
    bit hit;
    if (rst_n) begin
      m_eval(res, tk, red, rpc);
      if (res) begin
        if (m_br < PERF_MAX) m_br = m_br + 1;
        if (red && m_mis < PERF_MAX) m_mis = m_mis + 1;
        i = m_idx(ex_pc);
        hit = m_valid[i] && (m_tag[i] == m_tagof(ex_pc));
        if (hit) begin
          m_ctr[i] = tk ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                        : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
          if (tk) m_target[i] = ex_target;
        end else if (tk) begin
          m_valid[i]  = 1'b1;
          m_tag[i]    = m_tagof(ex_pc);
          m_target[i] = ex_target;
          m_ctr[i]    = ex_jump ? 3 : 2;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    bit res, tk, red, pt;
    logic [31:0] rpc;
    int i;
    if (!rst_n) begin
      check("cmp_rst_pred", {31'd0, if_pred_taken}, 32'd0);
      check("cmp_rst_redirect", {31'd0, ex_redirect}, 32'd0);
      check("cmp_rst_perf_br", {24'd0, perf_branches}, 32'd0);
      check("cmp_rst_perf_mis", {24'd0, perf_mispredicts}, 32'd0);
    end else begin
      i  = m_idx(if_pc);
      pt = m_valid[i] && (m_tag[i] == m_tagof(if_pc)) && (m_ctr[i] >= 2);
      check("cmp_pred_taken", {31'd0, if_pred_taken}, {31'd0, pt});
      if (pt) check("cmp_pred_target", if_pred_target, m_target[i]);
      m_eval(res, tk, red, rpc);
      check("cmp_ex_taken", {31'd0, ex_taken}, {31'd0, tk});
      check("cmp_redirect", {31'd0, ex_redirect}, {31'd0, red});
      if (red) check("cmp_redirect_pc", ex_redirect_pc, rpc);
      check("cmp_perf_br", {24'd0, perf_branches}, m_br);
      check("cmp_perf_mis", {24'd0, perf_mispredicts}, m_mis);
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic br, input logic jmp,
                       input logic [31:0] pc, input logic [2:0] f3, input logic [3:0] fl,
                       input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt,
                       input logic [31:0] ifpc);
    @(posedge clk);
    #1;
    ex_valid = v; ex_branch = br; ex_jump = jmp; ex_pc = pc; ex_funct3 = f3;
    ex_flags = fl; ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
    if_pc = ifpc;
  endtask

  task automatic idle(input logic [31:0] ifpc);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 4'd0, 32'h0, 1'b0, 32'h0, ifpc);
  endtask

  function automatic logic [31:0] rnd_pc();
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
    return 32'h1000 + ($urandom_range(0, 15) << 2) + ($urandom_range(0, 3) << 6);
  endfunction

  task automatic rand_cycle();
    logic [31:0] pc, tgt, ptgt, ifpc;
    int k;
    pc   = rnd_pc();
    tgt  = 32'h2000 + ($urandom_range(0, 3) << 2);
    ptgt = ($urandom_range(0, 1) == 1) ? tgt : 32'h2000 + ($urandom_range(0, 3) << 2);
    ifpc = ($urandom_range(0, 3) == 0) ? pc : rnd_pc();
    k    = $urandom_range(0, 9);
    drive(($urandom_range(0, 3) != 0), (k < 6), (k == 6), pc,
          3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), tgt,
          1'($urandom_range(0, 1)), ptgt, ifpc);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_clear();
    rst_n = 1'b1;
    ex_valid = 0; ex_branch = 0; ex_jump = 0; ex_pc = '0; ex_funct3 = '0;
    ex_flags = '0; ex_target = '0; ex_pred_taken = 0; ex_pred_target = '0;
    if_pc = 32'h100;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_pred", {31'd0, if_pred_taken}, 32'd0);
    check("reset_perf_br", {24'd0, perf_branches}, 32'd0);
    check("reset_perf_mis", {24'd0, perf_mispredicts}, 32'd0);
    rst_n = 1'b1;

    // BEQ taken, unpredicted
    drive(1, 1, 0, 32'h100, 3'b000, 4'b0001, 32'h140, 0, 32'h0, 32'h100);
    #2;
    check("beq_redirect", {31'd0, ex_redirect}, 32'd1);
    check("beq_redirect_pc", ex_redirect_pc, 32'h140);
    idle(32'h100);
    #2;
    check("beq_lookup_taken", {31'd0, if_pred_taken}, 32'd1);
    check("beq_lookup_target", if_pred_target, 32'h140);

    // BLTU: taken x3, not-taken, then not-taken again
    drive(1, 1, 0, 32'h200, 3'b110, 4'b0000, 32'h280, 0, 32'h0, 32'h200);
    #2 check("bltu1_redirect_pc", ex_redirect_pc, 32'h280);
    drive(1, 1, 0, 32'h200, 3'b110, 4'b0000, 32'h280, 1, 32'h280, 32'h200);
    #2 check("bltu2_no_redirect", {31'd0, ex_redirect}, 32'd0);
    drive(1, 1, 0, 32'h200, 3'b110, 4'b0000, 32'h280, 1, 32'h280, 32'h200);
    drive(1, 1, 0, 32'h200, 3'b110, 4'b0100, 32'h280, 1, 32'h280, 32'h200);
    #2;
    check("bltu4_taken", {31'd0, ex_taken}, 32'd0);
    check("bltu4_redirect_pc", ex_redirect_pc, 32'h204);
    idle(32'h200);
    #2 check("bltu_wt_still_taken", {31'd0, if_pred_taken}, 32'd1);
    drive(1, 1, 0, 32'h200, 3'b110, 4'b0100, 32'h280, 1, 32'h280, 32'h200);
    #2;
    check("bltu6_redirect", {31'd0, ex_redirect}, 32'd1);
    check("same_cycle_old_pred", {31'd0, if_pred_taken}, 32'd1);
    idle(32'h200);
    #2 check("bltu_wnt_not_taken", {31'd0, if_pred_taken}, 32'd0);

    // Aliasing BNE at 0x100 + 4*ENTRIES
    drive(1, 1, 0, 32'h140, 3'b001, 4'b0000, 32'h300, 0, 32'h0, 32'h140);
    #2 check("alias_redirect_pc", ex_redirect_pc, 32'h300);
    idle(32'h100);
    #2 check("alias_old_miss", {31'd0, if_pred_taken}, 32'd0);
    if_pc = 32'h140;
    #1 check("alias_new_target", if_pred_target, 32'h300);

    // funct3=010 predicted taken
    drive(1, 1, 0, 32'h400, 3'b010, 4'b0111, 32'h480, 1, 32'h480, 32'h400);
    #2;
    check("f3_010_taken", {31'd0, ex_taken}, 32'd0);
    check("f3_010_redirect_pc", ex_redirect_pc, 32'h404);
    idle(32'h400);
    #2 check("f3_010_no_alloc", {31'd0, if_pred_taken}, 32'd0);

    // JAL: miss, then hit with a wrong predicted target
    drive(1, 0, 1, 32'h600, 3'b000, 4'b0000, 32'h700, 0, 32'h0, 32'h600);
    #2 check("jal_redirect", {31'd0, ex_redirect}, 32'd1);
    idle(32'h600);
    #2 check("jal_lookup_target", if_pred_target, 32'h700);
    drive(1, 0, 1, 32'h600, 3'b000, 4'b0000, 32'h700, 1, 32'h680, 32'h600);
    #2 check("jal_wrong_target_pc", ex_redirect_pc, 32'h700);

    // Non-branch with a stale taken prediction
    drive(1, 0, 0, 32'h800, 3'b000, 4'b0001, 32'h900, 1, 32'h900, 32'h800);
    #2 check("nonbranch_redirect", {31'd0, ex_redirect}, 32'd0);
    idle(32'h0);
    #2;
    check("directed_perf_br", {24'd0, perf_branches}, 32'd10);
    check("directed_perf_mis", {24'd0, perf_mispredicts}, 32'd8);

    // Randomized traffic long enough to saturate the counters
    for (int n = 0; n < 1200; n++) rand_cycle();
    idle(32'h1000);
    #2 check("perf_br_saturated", {24'd0, perf_branches}, 32'd255);

    // Asynchronous reset in the middle of a cycle
    drive(0, 0, 0, 32'h0, 3'd0, 4'd0, 32'h0, 0, 32'h0, 32'h200);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_pred", {31'd0, if_pred_taken}, 32'd0);
    check("midreset_perf_br", {24'd0, perf_branches}, 32'd0);
    check("midreset_perf_mis", {24'd0, perf_mispredicts}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int n = 0; n < 200; n++) rand_cycle();
    idle(32'h0);
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
